// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core fetch path: state encoding,
// default widths and the branch-target field width.
package core_pkg;

  localparam int PC_W_DEF   = 10;
  localparam int LUT_AW_DEF = 5;
  localparam int TGT_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch look-up table: register array with one synchronous write port and
// one combinational read port. A same-cycle write is not visible to the read.
module branch_lut #(
  parameter int AW = 5,
  parameter int DW = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // table storage, cleared on reset, written on any state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // combinational read of the pre-write contents
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: program counter, absolute (LUT) and relative
// branches, start/halt handshake. Optional run-cycle counter on CycleCt is
// built only when FETCH_CYCLE_CNT_EN is defined.
//
// state  | meaning
// IDLE   | frozen, Pc = 0, waiting for Start low to launch
// RUN    | fetching, Pc advances by stall/halt/branch/increment rules
// HALTED | program finished, Done = 1, Pc frozen until Start high
module fetch_ctrl
  import core_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              Branch,
  input  logic              BranchAbs,
  input  logic [TGT_W-1:0]  Target,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutData,
  output logic [PC_W-1:0]   Pc,
  output logic              FetchValid,
  output logic              Done
`ifdef FETCH_CYCLE_CNT_EN
  ,
  output logic [31:0]       CycleCt
`endif
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] lut_rd;
  logic [PC_W-1:0] rel_off;

  branch_lut #(
    .AW (LUT_AW),
    .DW (PC_W)
  ) u_lut (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .we_i    (LutWe),
    .waddr_i (LutAddr),
    .wdata_i (LutData),
    .raddr_i (Target[LUT_AW-1:0]),
    .rdata_o (lut_rd)
  );

  // signed 8-bit offset widened to the PC width; the add wraps naturally
  assign rel_off = PC_W'(signed'(Target));

  // state and program-counter registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // next state and next Pc: Start > Stall > Halt > Branch > increment
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (!Start) state_d = RUN;
      end
      RUN: begin
        if (Start) begin
          state_d = IDLE;
          pc_d    = '0;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (Halt) begin
          state_d = HALTED;
        end else if (Branch) begin
          pc_d = BranchAbs ? lut_rd : pc_q + rel_off;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      HALTED: begin
        if (Start) begin
          state_d = IDLE;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // outputs decoded purely from registered state
  always_comb begin
    Pc         = pc_q;
    FetchValid = (state_q == RUN);
    Done       = (state_q == HALTED);
  end

`ifdef FETCH_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  // counts RUN cycles (stalls included), restarts on launch, saturates
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE && !Start) begin
      cyc_d = '0;
    end else if (state_q == RUN && !Start && cyc_q != 32'hFFFF_FFFF) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  // cycle counter register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign CycleCt = cyc_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed walk through launch, branches, LUT
// collision, stall/halt priority and the optional counter, then random
// traffic against a behavioural reference model.
module tb_fetch_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b1;
  logic       Stall = 1'b0;
  logic       Halt = 1'b0;
  logic       Branch = 1'b0;
  logic       BranchAbs = 1'b0;
  logic [7:0] Target = '0;
  logic       LutWe = 1'b0;
  logic [4:0] LutAddr = '0;
  logic [9:0] LutData = '0;
  logic [9:0] Pc;
  logic       FetchValid;
  logic       Done;
`ifdef FETCH_CYCLE_CNT_EN
  logic [31:0] CycleCt;
`endif

  fetch_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Stall      (Stall),
    .Halt       (Halt),
    .Branch     (Branch),
    .BranchAbs  (BranchAbs),
    .Target     (Target),
    .LutWe      (LutWe),
    .LutAddr    (LutAddr),
    .LutData    (LutData),
    .Pc         (Pc),
    .FetchValid (FetchValid),
    .Done       (Done)
`ifdef FETCH_CYCLE_CNT_EN
    ,
    .CycleCt    (CycleCt)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: mode 0 = stopped, 1 = running, 2 = finished
  int     m_mode;
  int     m_pc;
  longint m_cnt;
  int     m_lut [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_cnt  = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
  endtask

  task automatic model_edge();
    int off;
    if (m_mode == 0) begin
      if (!Start) begin
        m_mode = 1;
        m_pc   = 0;
        m_cnt  = 0;
      end
    end else if (m_mode == 1) begin
      if (Start) begin
        m_mode = 0;
        m_pc   = 0;
      end else begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (Stall) begin
          // hold
        end else if (Halt) begin
          m_mode = 2;
        end else if (Branch) begin
          if (BranchAbs) begin
            m_pc = m_lut[Target % 32];
          end else begin
            off  = (Target >= 128) ? int'(Target) - 256 : int'(Target);
            m_pc = (m_pc + off + 1024) % 1024;
          end
        end else begin
          m_pc = (m_pc + 1) % 1024;
        end
      end
    end else begin
      if (Start) begin
        m_mode = 0;
        m_pc   = 0;
      end
    end
    if (LutWe) m_lut[LutAddr] = int'(LutData);
  endtask

  task automatic check_all();
    chk("pc", 32'(Pc), 32'(m_pc));
    chk("fetch_valid", 32'(FetchValid), 32'(m_mode == 1));
    chk("done", 32'(Done), 32'(m_mode == 2));
`ifdef FETCH_CYCLE_CNT_EN
    chk("cycle_ct", CycleCt, 32'(m_cnt));
`endif
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cyc(input bit st, input bit sl, input bit ht, input bit br,
                     input bit ab, input int tg, input bit we, input int wa,
                     input int wd);
    Start     = st;
    Stall     = sl;
    Halt      = ht;
    Branch    = br;
    BranchAbs = ab;
    Target    = 8'(tg);
    LutWe     = we;
    LutAddr   = 5'(wa);
    LutData   = 10'(wd);
    step();
  endtask

  task automatic plain();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("reset_pc", 32'(Pc), 32'd0);

    @(posedge Clk);
    #1 Reset = 1'b1;

    // held frozen by Start
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("frozen_fv", 32'(FetchValid), 32'd0);

    // launch then count
    plain();
    chk("launch_pc", 32'(Pc), 32'd0);
    chk("launch_fv", 32'(FetchValid), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      plain();
      chk("count_pc", 32'(Pc), 32'(i));
    end

    // relative branch backwards
    while (m_pc != 20) plain();
    cyc(0, 0, 0, 1, 0, 8'hFB, 0, 0, 0);
    chk("rel_branch", 32'(Pc), 32'd15);

    // wrap at the top of the address space
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 1022);
    cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
    chk("abs_1022", 32'(Pc), 32'd1022);
    plain();
    plain();
    chk("wrap_pc", 32'(Pc), 32'd0);

    // absolute branch with a colliding write
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 500);
    while (m_pc != 7) plain();
    cyc(0, 0, 0, 1, 1, 3, 1, 3, 600);
    chk("collide_old", 32'(Pc), 32'd500);
    cyc(0, 0, 0, 1, 1, 3, 0, 0, 0);
    chk("collide_new", 32'(Pc), 32'd600);

    // stall beats halt, then halt, then abort
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 40);
    cyc(0, 0, 0, 1, 1, 4, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("stall_pc", 32'(Pc), 32'd40);
    chk("stall_done", 32'(Done), 32'd0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_pc", 32'(Pc), 32'd40);
    chk("halt_fv", 32'(FetchValid), 32'd0);
    cyc(0, 0, 0, 1, 0, 3, 0, 0, 0);
    chk("halt_frozen", 32'(Pc), 32'd40);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_pc", 32'(Pc), 32'd0);

    // ten run cycles, two stalled, the last one halting
    plain();
    for (int i = 0; i < 10; i++)
      cyc(0, (i == 2 || i == 5), (i == 9), 0, 0, 0, 0, 0, 0);
`ifdef FETCH_CYCLE_CNT_EN
    chk("cnt_ten", CycleCt, 32'd10);
`endif
    for (int i = 0; i < 3; i++) plain();
`ifdef FETCH_CYCLE_CNT_EN
    chk("cnt_held", CycleCt, 32'd10);
`endif
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // random traffic with one reset in the middle of a run
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        for (int k = 0; k < 4 && m_mode != 1; k++)
          cyc((m_mode == 2), 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) plain();
        Reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("midrun_reset_pc", 32'(Pc), 32'd0);
        @(posedge Clk);
        #1;
        Start = 1'b1;
        Reset = 1'b1;
      end
      cyc((m_mode == 2) ? ($urandom_range(99) < 25) : ($urandom_range(99) < 2),
          ($urandom_range(99) < 15),
          ($urandom_range(99) < 3),
          ($urandom_range(99) < 25),
          $urandom_range(1),
          int'($urandom_range(255)),
          ($urandom_range(99) < 20),
          int'($urandom_range(31)),
          int'($urandom_range(1023)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
